// File: rtl/ysyx_23060072_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_bus_arbiter
//
// Shares the core's single memory port between instruction fetch (IFU) and
// the load/store stage (LSU). One request is in flight at a time: it is
// accepted in IDLE, presented downstream in REQ, and its single response is
// routed back to the owning master in WAIT.
// LSU has fixed priority. A starvation counter forces an IFU win after
// STARVE_LIMIT consecutive LSU grants made while the IFU was waiting. A
// controller flush discards the pending fetch without aborting the memory
// transaction.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   ifu_req_valid_i/ready_o/addr_i  fetch request handshake
//   ifu_flush_i                     drop any outstanding or same-cycle fetch
//   ifu_resp_valid_o/rdata_o/err_o  fetch response (one-cycle pulse)
//   lsu_req_*                       LSU request (addr, wen, wdata, wmask)
//   lsu_resp_valid_o/rdata_o/err_o  LSU response (one-cycle pulse)
//   mem_req_*                       downstream request, held stable in REQ
//   mem_resp_valid_i/rdata_i/err_i  downstream response, no back-pressure
// ---------------------------------------------------------------------------
module ysyx_23060072_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifu_req_valid_i,
    output logic        ifu_req_ready_o,
    input  logic [31:0] ifu_addr_i,
    input  logic        ifu_flush_i,
    output logic        ifu_resp_valid_o,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_resp_err_o,

    input  logic        lsu_req_valid_i,
    output logic        lsu_req_ready_o,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_wen_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_wmask_i,
    output logic        lsu_resp_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_err_o,

    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_resp_err_i
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        owner_reg;          // 0 = IFU, 1 = LSU
    logic        drop_reg;
    logic [2:0]  starve_cnt_reg;
    logic [31:0] addr_reg;
    logic        wen_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wmask_reg;

    logic        lsu_win;
    logic        ifu_win;
    logic        lsu_grant;
    logic        ifu_grant;
    logic        req_active;
    logic        resp_fire;
    logic        flush_hit;
    logic        resp_drop;

    // Per-master response channels: index 0 = IFU, 1 = LSU.
    logic [1:0]  chan_pulse;
    logic        resp_valid_reg [2];
    logic [31:0] rdata_reg      [2];
    logic        err_reg        [2];

    // The IFU is forced to win only while it is actually waiting; a flush
    // blocks an IFU grant in the same cycle even when it holds priority.
    assign lsu_win = lsu_req_valid_i &&
                     !((starve_cnt_reg == LIMIT) && ifu_req_valid_i);
    assign ifu_win = !lsu_win && ifu_req_valid_i && !ifu_flush_i;

    assign resp_fire = (state_reg == ST_WAIT) && mem_resp_valid_i;
    // A flush aimed at our fetch counts even in the response cycle itself.
    assign flush_hit = ifu_flush_i && !owner_reg && (state_reg != ST_IDLE);
    assign resp_drop = drop_reg || flush_hit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (lsu_grant || ifu_grant) state_next = ST_REQ;
            ST_REQ:  if (mem_req_ready_i)        state_next = ST_WAIT;
            ST_WAIT: if (mem_resp_valid_i)       state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        lsu_grant  = 1'b0;
        ifu_grant  = 1'b0;
        req_active = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                lsu_grant = lsu_win;
                ifu_grant = ifu_win;
            end
            ST_REQ:  req_active = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Request payload, owner, starvation, drop ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_reg      <= 1'b0;
            drop_reg       <= 1'b0;
            starve_cnt_reg <= 3'd0;
            addr_reg       <= 32'd0;
            wen_reg        <= 1'b0;
            wdata_reg      <= 32'd0;
            wmask_reg      <= 4'd0;
        end else begin
            if (lsu_grant) begin
                owner_reg <= 1'b1;
                addr_reg  <= lsu_addr_i;
                wen_reg   <= lsu_wen_i;
                wdata_reg <= lsu_wdata_i;
                wmask_reg <= lsu_wmask_i;
                if (!ifu_req_valid_i) begin
                    starve_cnt_reg <= 3'd0;
                end else if (starve_cnt_reg != LIMIT) begin
                    starve_cnt_reg <= starve_cnt_reg + 3'd1;
                end
            end else if (ifu_grant) begin
                // Fetches are always reads: never leak LSU write payload.
                owner_reg      <= 1'b0;
                addr_reg       <= ifu_addr_i;
                wen_reg        <= 1'b0;
                wdata_reg      <= 32'd0;
                wmask_reg      <= 4'd0;
                starve_cnt_reg <= 3'd0;
            end

            if (state_next == ST_IDLE) begin
                drop_reg <= 1'b0;
            end else if (flush_hit) begin
                drop_reg <= 1'b1;
            end
        end
    end

    // ---------------- Response routing ----------------
    // Data and error only update when a pulse is delivered, so they hold
    // their last value between pulses (a dropped fetch leaves them alone).
    assign chan_pulse[0] = resp_fire && !owner_reg && !resp_drop;
    assign chan_pulse[1] = resp_fire &&  owner_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_resp
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    resp_valid_reg[gi] <= 1'b0;
                    rdata_reg[gi]      <= 32'd0;
                    err_reg[gi]        <= 1'b0;
                end else begin
                    resp_valid_reg[gi] <= chan_pulse[gi];
                    if (chan_pulse[gi]) begin
                        rdata_reg[gi] <= mem_rdata_i;
                        err_reg[gi]   <= mem_resp_err_i;
                    end
                end
            end
        end
    endgenerate

    assign ifu_req_ready_o  = ifu_grant;
    assign lsu_req_ready_o  = lsu_grant;

    assign ifu_resp_valid_o = resp_valid_reg[0];
    assign ifu_rdata_o      = rdata_reg[0];
    assign ifu_resp_err_o   = err_reg[0];
    assign lsu_resp_valid_o = resp_valid_reg[1];
    assign lsu_rdata_o      = rdata_reg[1];
    assign lsu_resp_err_o   = err_reg[1];

    assign mem_req_valid_o  = req_active;
    assign mem_addr_o       = addr_reg;
    assign mem_wen_o        = wen_reg;
    assign mem_wdata_o      = wdata_reg;
    assign mem_wmask_o      = wmask_reg;

endmodule

// File: tb/tb_ysyx_23060072_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060072_bus_arbiter
//
// Directed bench for the IFU/LSU memory arbiter. Expected responses are
// pushed to per-master queues when a grant is seen and popped when the DUT
// pulses a response. A small memory model answers the cycle after a
// handshake; manual mode lets steps drive the memory side directly.
// ---------------------------------------------------------------------------
module tb_ysyx_23060072_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid_i;
    logic        ifu_req_ready_o;
    logic [31:0] ifu_addr_i;
    logic        ifu_flush_i;
    logic        ifu_resp_valid_o;
    logic [31:0] ifu_rdata_o;
    logic        ifu_resp_err_o;
    logic        lsu_req_valid_i;
    logic        lsu_req_ready_o;
    logic [31:0] lsu_addr_i;
    logic        lsu_wen_i;
    logic [31:0] lsu_wdata_i;
    logic [3:0]  lsu_wmask_i;
    logic        lsu_resp_valid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_resp_err_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_resp_err_i;

    ysyx_23060072_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ifu_req_valid_i  (ifu_req_valid_i),
        .ifu_req_ready_o  (ifu_req_ready_o),
        .ifu_addr_i       (ifu_addr_i),
        .ifu_flush_i      (ifu_flush_i),
        .ifu_resp_valid_o (ifu_resp_valid_o),
        .ifu_rdata_o      (ifu_rdata_o),
        .ifu_resp_err_o   (ifu_resp_err_o),
        .lsu_req_valid_i  (lsu_req_valid_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wen_i        (lsu_wen_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_wmask_i      (lsu_wmask_i),
        .lsu_resp_valid_o (lsu_resp_valid_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_resp_err_o   (lsu_resp_err_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_wen_o        (mem_wen_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wmask_o      (mem_wmask_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_rdata_i      (mem_rdata_i),
        .mem_resp_err_i   (mem_resp_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bit          auto_mem = 1'b1;
    logic [32:0] ifu_exp[$];
    logic [32:0] lsu_exp[$];
    bit          grant_log[$];

    // Memory contents model: {err, rdata} for an address.
    function automatic logic [32:0] model(input logic [31:0] a);
        logic [31:0] d;
        d = (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_0F0F);
        return {a[4], d};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [159:0] all_outs();
        return 160'({ifu_req_ready_o, ifu_resp_valid_o, ifu_rdata_o, ifu_resp_err_o,
                     lsu_req_ready_o, lsu_resp_valid_o, lsu_rdata_o, lsu_resp_err_o,
                     mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o});
    endfunction

    // One clock: log grants (pushing expectations), step the edge, pop and
    // compare responses, then let the memory model react.
    task automatic cyc();
        logic        fire;
        logic [31:0] faddr;
        logic [32:0] m;
        #1;
        if (lsu_req_ready_o && lsu_req_valid_i) begin
            grant_log.push_back(1'b1);
            lsu_exp.push_back(model(lsu_addr_i));
            $display("grant LSU addr=%h", lsu_addr_i);
        end
        if (ifu_req_ready_o && ifu_req_valid_i) begin
            grant_log.push_back(1'b0);
            ifu_exp.push_back(model(ifu_addr_i));
            $display("grant IFU addr=%h", ifu_addr_i);
        end
        fire  = mem_req_valid_o && mem_req_ready_i;
        faddr = mem_addr_o;
        @(posedge clk);
        #1;
        if (ifu_resp_valid_o) begin
            $display("ifu resp rdata=%h err=%b", ifu_rdata_o, ifu_resp_err_o);
            if (ifu_exp.size() == 0) chk("ifu_unexpected_resp", 160'(1), 160'(0));
            else chk("ifu_resp", 160'({ifu_resp_err_o, ifu_rdata_o}), 160'(ifu_exp.pop_front()));
        end
        if (lsu_resp_valid_o) begin
            $display("lsu resp rdata=%h err=%b", lsu_rdata_o, lsu_resp_err_o);
            if (lsu_exp.size() == 0) chk("lsu_unexpected_resp", 160'(1), 160'(0));
            else chk("lsu_resp", 160'({lsu_resp_err_o, lsu_rdata_o}), 160'(lsu_exp.pop_front()));
        end
        if (auto_mem) begin
            m                = model(faddr);
            mem_req_ready_i  = 1'b1;
            mem_resp_valid_i = fire;
            mem_rdata_i      = fire ? m[31:0] : 32'd0;
            mem_resp_err_i   = fire ? m[32] : 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((ifu_exp.size() != 0 || lsu_exp.size() != 0) && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_ifu_pending"}, 160'(ifu_exp.size()), 160'(0));
        chk({tag, "_lsu_pending"}, 160'(lsu_exp.size()), 160'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g2[2];
        bit g10[10];
        int n;
        g2  = '{1'b1, 1'b0};
        g10 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        ifu_req_valid_i = 1'b0; ifu_addr_i = 32'd0; ifu_flush_i = 1'b0;
        lsu_req_valid_i = 1'b0; lsu_addr_i = 32'd0; lsu_wen_i = 1'b0;
        lsu_wdata_i = 32'd0; lsu_wmask_i = 4'd0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
        mem_rdata_i = 32'd0; mem_resp_err_i = 1'b0;

        // ---- reset ----
        repeat (3) cyc();
        chk("reset_outputs", all_outs(), 160'(0));
        rst_n = 1'b1;
        cyc();

        // ---- IFU-only fetch; LSU write payload lingering on its inputs ----
        lsu_wen_i = 1'b1; lsu_wdata_i = 32'hFFFF_FFFF; lsu_wmask_i = 4'hF;
        lsu_addr_i = 32'h1234_5678;
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0000;
        #1;
        chk("t1_ready", 160'({ifu_req_ready_o, lsu_req_ready_o}), 160'(2'b10));
        cyc();
        ifu_req_valid_i = 1'b0;
        chk("t1_mem_req", 160'({mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o}),
            160'({1'b1, 32'h8000_0000, 1'b0, 32'd0, 4'd0}));
        cyc();
        chk("t1_no_early_resp", 160'(ifu_resp_valid_o), 160'(0));
        cyc();
        chk("t1_resp_T3", 160'({ifu_resp_valid_o, lsu_resp_valid_o, ifu_rdata_o}),
            160'({1'b1, 1'b0, 32'h0000_0413}));
        cyc();
        chk("t1_pulse_end", 160'({ifu_resp_valid_o, lsu_resp_valid_o, ifu_rdata_o}),
            160'({1'b0, 1'b0, 32'h0000_0413}));
        drain("t1");

        // ---- simultaneous IFU and LSU store ----
        grant_log.delete();
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0004;
        lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_1000; lsu_wen_i = 1'b1;
        lsu_wdata_i = 32'hDEAD_BEEF; lsu_wmask_i = 4'hF;
        #1;
        chk("t2_ready", 160'({ifu_req_ready_o, lsu_req_ready_o}), 160'(2'b01));
        cyc();
        lsu_req_valid_i = 1'b0;
        chk("t2_mem_req", 160'({mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o}),
            160'({1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}));
        chk("t2_ifu_wait", 160'(ifu_req_ready_o), 160'(0));
        cyc();
        cyc();
        chk("t2_lsu_resp_ifu_ready", 160'({lsu_resp_valid_o, ifu_req_ready_o}), 160'(2'b11));
        cyc();
        ifu_req_valid_i = 1'b0;
        drain("t2");
        chk("t2_grant_count", 160'(grant_log.size()), 160'(2));
        for (int i = 0; i < grant_log.size() && i < 2; i++)
            chk($sformatf("t2_grant%0d", i), 160'(grant_log[i]), 160'(g2[i]));

        // ---- starvation guard ----
        grant_log.delete();
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0008;
        lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_2000; lsu_wen_i = 1'b0;
        n = 0;
        while (grant_log.size() < 10 && n < 80) begin
            cyc();
            n++;
        end
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
        drain("t3");
        chk("t3_grant_count", 160'(grant_log.size()), 160'(10));
        for (int i = 0; i < grant_log.size() && i < 10; i++)
            chk($sformatf("t3_grant%0d", i), 160'(grant_log[i]), 160'(g10[i]));

        // ---- flush while in WAIT ----
        auto_mem = 1'b0; mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b0;
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0010;
        cyc();
        ifu_req_valid_i = 1'b0;
        cyc();
        void'(ifu_exp.pop_back());
        ifu_flush_i = 1'b1;
        cyc();
        ifu_flush_i = 1'b0;
        cyc();
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h1111_1111; mem_resp_err_i = 1'b1;
        cyc();
        mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0;
        chk("t4_dropped", 160'(ifu_resp_valid_o), 160'(0));
        auto_mem = 1'b1;
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0014;
        #1;
        chk("t4_regrant", 160'(ifu_req_ready_o), 160'(1));
        cyc();
        ifu_req_valid_i = 1'b0;
        drain("t4");

        // ---- flush coincident with the memory response ----
        auto_mem = 1'b0; mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b0;
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0018;
        cyc();
        ifu_req_valid_i = 1'b0;
        cyc();
        void'(ifu_exp.pop_back());
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h2222_2222; ifu_flush_i = 1'b1;
        cyc();
        mem_resp_valid_i = 1'b0; ifu_flush_i = 1'b0;
        chk("t4b_dropped", 160'(ifu_resp_valid_o), 160'(0));
        auto_mem = 1'b1;
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_001C;
        #1;
        chk("t4b_regrant", 160'(ifu_req_ready_o), 160'(1));
        cyc();
        ifu_req_valid_i = 1'b0;
        drain("t4b");

        // ---- downstream stall for 5 cycles ----
        auto_mem = 1'b0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
        lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_3000; lsu_wen_i = 1'b1;
        lsu_wdata_i = 32'h1234_5678; lsu_wmask_i = 4'h3;
        cyc();
        lsu_addr_i = 32'h8000_3004; lsu_wdata_i = 32'h0BAD_F00D; lsu_wmask_i = 4'hC;
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0020;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_stall%0d_req", i),
                160'({mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o}),
                160'({1'b1, 32'h8000_3000, 1'b1, 32'h1234_5678, 4'h3}));
            chk($sformatf("t5_stall%0d_ready", i),
                160'({ifu_req_ready_o, lsu_req_ready_o}), 160'(0));
            cyc();
        end
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
        auto_mem = 1'b1; mem_req_ready_i = 1'b1;
        drain("t5");

        // ---- reset while in WAIT ----
        auto_mem = 1'b0; mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b0;
        lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_4000; lsu_wen_i = 1'b0;
        cyc();
        lsu_req_valid_i = 1'b0;
        cyc();
        lsu_exp.delete();
        rst_n = 1'b0;
        cyc();
        chk("t6_reset_outputs", all_outs(), 160'(0));
        rst_n = 1'b1;
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h3333_3333;
        cyc();
        mem_resp_valid_i = 1'b0;
        chk("t6_late_resp", 160'({ifu_resp_valid_o, lsu_resp_valid_o, mem_req_valid_o}), 160'(0));
        cyc();
        chk("t6_late_resp2", 160'({ifu_resp_valid_o, lsu_resp_valid_o, lsu_rdata_o}), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060072_bus_arbiter.md
# ysyx_23060072_bus_arbiter

Two-master, one-slave arbiter sharing the core's single memory port between instruction fetch (IFU) and the load/store stage (LSU). It accepts one request at a time, forwards it to memory, and routes the single response back to the owner. Priority is fixed LSU-first, with a starvation guard for the IFU and a flush path that discards in-flight fetches after a jump or trap redirect. The block sits between `if_stage`/`lsu_stage` and the memory/SoC bridge.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive LSU grants made while the IFU waits before the IFU is forced to win. Range 1–7.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ifu_req_valid_i` in 1 / `ifu_req_ready_o` out 1 / `ifu_addr_i` in 32: fetch request handshake and address.
- `ifu_flush_i` in 1: controller redirect; any outstanding or same-cycle fetch is dropped.
- `ifu_resp_valid_o` out 1 / `ifu_rdata_o` out 32 / `ifu_resp_err_o` out 1: fetch response, one-cycle pulse.
- `lsu_req_valid_i` in 1 / `lsu_req_ready_o` out 1 / `lsu_addr_i` in 32 / `lsu_wen_i` in 1 / `lsu_wdata_i` in 32 / `lsu_wmask_i` in 4: LSU request.
- `lsu_resp_valid_o` out 1 / `lsu_rdata_o` out 32 / `lsu_resp_err_o` out 1: LSU response, one-cycle pulse.
- `mem_req_valid_o` out 1 / `mem_req_ready_i` in 1 / `mem_addr_o` out 32 / `mem_wen_o` out 1 / `mem_wdata_o` out 32 / `mem_wmask_o` out 4: downstream request.
- `mem_resp_valid_i` in 1 / `mem_rdata_i` in 32 / `mem_resp_err_i` in 1: downstream response. No back-pressure.

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: `owner` (0 = IFU, 1 = LSU), `drop`, `starve_cnt[2:0]`, and latched mem payload.
- IDLE, winner selection:
  - LSU wins if `lsu_req_valid_i` and not (`starve_cnt==STARVE_LIMIT` and `ifu_req_valid_i`).
  - Otherwise the IFU wins if `ifu_req_valid_i` and not `ifu_flush_i`.
- `*_req_ready_o` is high only in IDLE and only for the winner (combinational). On that edge:
  - latch payload and `owner`; go to REQ;
  - for an IFU grant, force `mem_wen_o`=0, `mem_wdata_o`=0, `mem_wmask_o`=0.
- REQ: `mem_req_valid_o`=1 with stable payload. When `mem_req_ready_i`=1, go to WAIT.
- WAIT: on `mem_resp_valid_i`=1, register rdata/err to the owner's response outputs, pulse the owner's resp_valid for one cycle unless suppressed by `drop`, and go to IDLE.
- `mem_resp_valid_i` outside WAIT is ignored.
- Starvation counter:
  - +1 (saturating at `STARVE_LIMIT`) on an LSU grant while `ifu_req_valid_i`=1;
  - cleared on any IFU grant, and on an LSU grant while `ifu_req_valid_i`=0.
- Drop flag:
  - set when `ifu_flush_i`=1 while `owner`=IFU in REQ or WAIT, including the response cycle itself;
  - cleared on entry to IDLE.
  - A dropped fetch still completes on the mem side; `ifu_resp_valid_o` stays 0.
- Flush while `owner`=LSU has no effect.

## Timing
- Reset: state IDLE, all `*_valid_o`, `*_ready_o`, `*_err_o` = 0; all data, address and mask outputs = 0; `owner`=0, `drop`=0, `starve_cnt`=0.
- Cycle-level latency:
  - Accept at cycle T.
  - `mem_req_valid_o` high from T+1.
  - With `mem_req_ready_i` at T+1: WAIT at T+2.
  - Memory response at cycle R ≥ T+2: requester resp_valid at R+1, with state IDLE at R+1.
  - The next accept can occur at R+1.
- Minimum turnaround: 3 cycles per transaction.
- Response data and err outputs hold their last value between pulses.
- `rst_n` low mid-transaction: immediate return to reset values at the next edge; the in-flight mem response is not forwarded.
- Both requesters must hold valid and payload until their ready is seen.

## Test plan
- Reset, then IFU-only fetch of 0x8000_0000, memory ready at once and rdata 0x0000_0413 two cycles later -> `ifu_resp_valid_o` pulses at T+3 with 0x0000_0413; `lsu_resp_valid_o` stays 0.
- IFU and LSU valid in the same cycle, LSU store to 0x8000_1000 with wdata 0xDEAD_BEEF and wmask 0xF -> LSU granted first with mem payload exact; IFU granted on the first IDLE after the LSU response.
- IFU continuously valid, LSU valid back-to-back, `STARVE_LIMIT`=4 -> grant sequence LSU, LSU, LSU, LSU, IFU, LSU…; `starve_cnt` clears after the IFU grant.
- IFU fetch in WAIT, `ifu_flush_i` pulsed, then memory responds -> no `ifu_resp_valid_o`; FSM reaches IDLE and the next IFU request is granted normally. Repeat with flush coincident with `mem_resp_valid_i`: same result.
- `mem_req_ready_i` held low for 5 cycles -> `mem_req_valid_o` and payload stable across all 5; both `*_req_ready_o` stay 0.
- `rst_n` asserted while in WAIT -> all outputs 0 next cycle; a late `mem_resp_valid_i` produces no response pulse.
